reli_rx_seq_check: RTL and testbench
====================================

Name: reli_rx_seq_check

Overview:
Receive-side counterpart of the reliable transmit path. It sits between the receive parser/MAC side and the host path. Per packet it checks the packet sequence number (PSN) against a per-flow expected-PSN table and forwards in-order packets. Out-of-order and duplicate packets are dropped. It emits one ACK/NACK metadata word per reliable packet for the reliable transmit path to consume.

Parameters:
DATA_WIDTH, 128, AXIS data width
KEEP_WIDTH, DATA_WIDTH/8, AXIS keep width
USER_WIDTH, 71, AXIS tuser width; passed through unchanged
FLOW_IDX_WIDTH, 5, flow index width; table depth is 2**FLOW_IDX_WIDTH
PSN_WIDTH, 32, sequence number width
PSN_OFFSET, 0, bit offset of PSN in tuser
FLOW_OFFSET, 32, bit offset of flow index in tuser
RELI_FLAG_OFFSET, 37, bit offset of the reliable-packet flag in tuser

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
s_axis_tdata/tkeep/tvalid/tready/tlast/tuser  in/in/in/out/in/in  DATA_WIDTH/KEEP_WIDTH/1/1/1/USER_WIDTH  received packet stream
m_axis_tdata/tkeep/tvalid/tready/tlast/tuser  out/out/out/in/out/out  same widths  accepted packet stream
m_ack_info  out  2+FLOW_IDX_WIDTH+PSN_WIDTH  {type[1:0], flow_idx, psn}; type 01=ACK, 10=NACK
m_ack_valid  out  1  ACK word valid
m_ack_ready  in  1  ACK word ready
flow_clr_valid  in  1  single-cycle strobe: invalidate one table entry
flow_clr_idx  in  FLOW_IDX_WIDTH  entry to invalidate
stat_fwd_cnt  out  32  forwarded-packet counter
stat_drop_cnt  out  32  dropped-packet counter

Behaviour:
- Reset values: m_axis_tvalid=0, s_axis_tready=0, m_ack_valid=0, m_ack_info=0, all table valid bits=0, counters=0, FSM=IDLE.
- Table entry: {valid, expected_psn[PSN_WIDTH-1:0]}, register array.
- FSM states: IDLE, LOOKUP, FORWARD, DROP, ACK.
- IDLE: s_axis_tready=0. When s_axis_tvalid=1, latch flow_idx, psn and reli flag from the head-beat tuser without consuming the beat. Next state: LOOKUP.
- LOOKUP (1 cycle): read the entry and decide using d = (psn - expected) mod 2**PSN_WIDTH.
  - reli=0 → FORWARD, no ACK.
  - entry invalid → FORWARD, accepted as the first packet. Set expected on tlast.
  - d==0 → FORWARD, ACK with psn.
  - 1 <= d <= 2**(PSN_WIDTH-1)-1 (ahead) → DROP, NACK with expected.
  - otherwise (behind/duplicate) → DROP, ACK with expected-1.
- FORWARD: combinational pass-through. m_axis_* = s_axis_*, s_axis_tready = m_axis_tready.
  - First output beat no earlier than 2 cycles after s_axis_tvalid rises in IDLE.
  - On the accepted tlast beat: write expected = psn+1 (wraps at 2**PSN_WIDTH, e.g. 0xFFFFFFFF→0) and valid=1. Increment stat_fwd_cnt.
  - Next state: ACK if an ACK is pending, else IDLE.
- DROP: s_axis_tready=1 and m_axis_tvalid=0. Consume beats until tlast, then increment stat_drop_cnt and go to ACK.
- ACK: when m_ack_valid==0 or m_ack_ready==1, load m_ack_info, set m_ack_valid=1, go to IDLE. Otherwise stall in ACK (back-pressure upstream).
  - m_ack_valid holds until m_ack_ready; m_ack_info is stable while valid && !ready.
- Simultaneous events:
  - flow_clr and tlast write to the same index in the same cycle → clear wins (valid=0).
  - flow_clr to a different index → both take effect.
  - flow_clr to an entry already latched in LOOKUP/FORWARD does not change the current decision.
- Single-beat packets (tlast on head) follow the same path. Counters wrap at 2**32.
- Reset mid-packet: everything returns to reset values immediately, including the table. A partial packet already emitted is not terminated; downstream handles truncation.

Optional Feature:
RELI_RX_STAT_EN:
- Defined: stat_fwd_cnt and stat_drop_cnt are implemented as described.
- Not defined: no counter registers exist and both ports are tied to 0.
- All other behaviour is identical in both cases.

Test Plan:
- After reset, flow 3 invalid; reli packet psn=100, 4 beats → forwarded unchanged. ACK {01,3,100}. Entry 3 expected=101. stat_fwd_cnt=1.
- Flow 3 expected=101; psn=101 then psn=101 again → first forwarded with ACK {01,3,101}. Second dropped with ACK {01,3,101}, all beats consumed, stat_drop_cnt=1.
- Flow 3 expected=102; psn=105 → dropped, NACK {10,3,102}, entry unchanged. Wrap case: expected=0xFFFFFFFF, psn=0xFFFFFFFF → forwarded, expected becomes 0.
- reli=0 packet on flow 7 with arbitrary psn → forwarded, no ACK generated, table untouched.
- m_ack_ready=0 for 20 cycles while two reliable packets arrive → second packet stalls in ACK. ACK words are delivered in order once m_ack_ready=1, with no loss or duplication.
- flow_clr_idx=3 on the same cycle as tlast of a flow-3 in-order packet → entry 3 invalid afterwards; next flow-3 packet psn=500 is accepted. Separately, rst asserted mid-FORWARD → all outputs 0 the next cycle.

Source files
------------

// File: rtl/reli_rx_seq_check_if.sv
// -----------------------------------------------------------------------------
// reli_rx_seq_check_if
// AXI-Stream style packet bus used on both sides of reli_rx_seq_check.
//   tdata/tkeep/tlast/tuser : beat payload, qualified by tvalid
//   tvalid / tready         : per-beat handshake
// Modports: master drives the payload and consumes tready; slave is the mirror.
// -----------------------------------------------------------------------------
interface reli_rx_seq_check_if #(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned USER_WIDTH = 71
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic [USER_WIDTH-1:0] tuser;

  modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/reli_rx_seq_check.sv
// -----------------------------------------------------------------------------
// reli_rx_seq_check
// Receive-side PSN checker. Per packet, compares the PSN carried in tuser with a
// per-flow expected-PSN table, forwards in-order (and non-reliable) packets,
// drops ahead/duplicate packets, and emits one ACK/NACK word per reliable
// packet.
//
// Ports:
//   i_clk, i_rst          : clock, synchronous active-high reset
//   s_axis (slave)        : received packet stream
//   m_axis (master)       : accepted packet stream (combinational pass-through)
//   o_ack_info            : {type[1:0], flow_idx, psn}; 01 = ACK, 10 = NACK
//   o_ack_valid/i_ack_ready : ACK word handshake
//   i_flow_clr_valid/idx  : one-cycle strobe invalidating one table entry
//   o_stat_fwd_cnt        : forwarded-packet counter
//   o_stat_drop_cnt       : dropped-packet counter
//
// Build option: define RELI_RX_STAT_EN to implement the two statistics
// counters; otherwise both stat ports are tied to zero.
// -----------------------------------------------------------------------------
module reli_rx_seq_check #(
  parameter int unsigned DATA_WIDTH       = 128,
  parameter int unsigned KEEP_WIDTH       = DATA_WIDTH / 8,
  parameter int unsigned USER_WIDTH       = 71,
  parameter int unsigned FLOW_IDX_WIDTH   = 5,
  parameter int unsigned PSN_WIDTH        = 32,
  parameter int unsigned PSN_OFFSET       = 0,
  parameter int unsigned FLOW_OFFSET      = 32,
  parameter int unsigned RELI_FLAG_OFFSET = 37
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  reli_rx_seq_check_if.slave                    s_axis,
  reli_rx_seq_check_if.master                   m_axis,
  output logic [2+FLOW_IDX_WIDTH+PSN_WIDTH-1:0] o_ack_info,
  output logic                                  o_ack_valid,
  input  logic                                  i_ack_ready,
  input  logic                                  i_flow_clr_valid,
  input  logic [FLOW_IDX_WIDTH-1:0]             i_flow_clr_idx,
  output logic [31:0]                           o_stat_fwd_cnt,
  output logic [31:0]                           o_stat_drop_cnt
);

  localparam int unsigned Depth    = 2 ** FLOW_IDX_WIDTH;
  localparam logic [1:0]  TypeAck  = 2'b01;
  localparam logic [1:0]  TypeNack = 2'b10;

  typedef enum logic [2:0] {StIdle, StLookup, StForward, StDrop, StAck} state_e;

  state_e                          r_state;
  logic [FLOW_IDX_WIDTH-1:0]       r_flow;
  logic [PSN_WIDTH-1:0]            r_psn;
  logic                            r_reli;
  logic                            r_ack_pend;
  logic [1:0]                      r_ack_type;
  logic [PSN_WIDTH-1:0]            r_ack_psn;
  logic [Depth-1:0]                r_tbl_vld;
  logic [PSN_WIDTH-1:0]            r_tbl_exp [Depth];
  logic [2+FLOW_IDX_WIDTH+PSN_WIDTH-1:0] r_ack_info;
  logic                            r_ack_valid;

  logic                 w_fwd;
  logic                 w_drop;
  logic                 w_s_ready;
  logic                 w_beat_last;
  logic [PSN_WIDTH-1:0] w_exp;
  logic [PSN_WIDTH-1:0] w_dist;

  assign w_fwd       = (r_state == StForward);
  assign w_drop      = (r_state == StDrop);
  assign w_s_ready   = w_drop | (w_fwd & m_axis.tready);
  assign w_beat_last = s_axis.tvalid & w_s_ready & s_axis.tlast;
  assign w_exp       = r_tbl_exp[r_flow];
  // Modular distance: top half of the range counts as "behind".
  assign w_dist      = r_psn - w_exp;

  assign s_axis.tready = w_s_ready;
  assign m_axis.tvalid = w_fwd & s_axis.tvalid;
  assign m_axis.tdata  = w_fwd ? s_axis.tdata : {DATA_WIDTH{1'b0}};
  assign m_axis.tkeep  = w_fwd ? s_axis.tkeep : {KEEP_WIDTH{1'b0}};
  assign m_axis.tlast  = w_fwd & s_axis.tlast;
  assign m_axis.tuser  = w_fwd ? s_axis.tuser : {USER_WIDTH{1'b0}};

  assign o_ack_info  = r_ack_info;
  assign o_ack_valid = r_ack_valid;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_flow      <= '0;
      r_psn       <= '0;
      r_reli      <= 1'b0;
      r_ack_pend  <= 1'b0;
      r_ack_type  <= '0;
      r_ack_psn   <= '0;
      r_tbl_vld   <= '0;
      r_ack_info  <= '0;
      r_ack_valid <= 1'b0;
    end else begin
      if (r_ack_valid && i_ack_ready) begin
        r_ack_valid <= 1'b0;
      end
      case (r_state)
        StIdle: begin
          // Peek the head beat; it is consumed later in FORWARD or DROP.
          if (s_axis.tvalid) begin
            r_flow  <= s_axis.tuser[FLOW_OFFSET +: FLOW_IDX_WIDTH];
            r_psn   <= s_axis.tuser[PSN_OFFSET +: PSN_WIDTH];
            r_reli  <= s_axis.tuser[RELI_FLAG_OFFSET];
            r_state <= StLookup;
          end
        end
        StLookup: begin
          r_ack_pend <= 1'b0;
          r_state    <= StForward;
          if (r_reli) begin
            r_ack_pend <= 1'b1;
            if (!r_tbl_vld[r_flow] || (w_dist == '0)) begin
              r_ack_type <= TypeAck;
              r_ack_psn  <= r_psn;
            end else if (!w_dist[PSN_WIDTH-1]) begin
              r_state    <= StDrop;
              r_ack_type <= TypeNack;
              r_ack_psn  <= w_exp;
            end else begin
              r_state    <= StDrop;
              r_ack_type <= TypeAck;
              r_ack_psn  <= w_exp - PSN_WIDTH'(1);
            end
          end
        end
        StForward: begin
          if (w_beat_last) begin
            if (r_reli) begin
              r_tbl_exp[r_flow] <= r_psn + PSN_WIDTH'(1);
              r_tbl_vld[r_flow] <= 1'b1;
            end
            r_state <= r_ack_pend ? StAck : StIdle;
          end
        end
        StDrop: begin
          if (w_beat_last) begin
            r_state <= StAck;
          end
        end
        StAck: begin
          if (!r_ack_valid || i_ack_ready) begin
            r_ack_info  <= {r_ack_type, r_flow, r_ack_psn};
            r_ack_valid <= 1'b1;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
      // Placed after the tlast write so a same-index clear takes priority.
      if (i_flow_clr_valid) begin
        r_tbl_vld[i_flow_clr_idx] <= 1'b0;
      end
    end
  end

`ifdef RELI_RX_STAT_EN
  logic [31:0] r_fwd_cnt;
  logic [31:0] r_drop_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_fwd_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_fwd && w_beat_last) begin
        r_fwd_cnt <= r_fwd_cnt + 32'd1;
      end
      if (w_drop && w_beat_last) begin
        r_drop_cnt <= r_drop_cnt + 32'd1;
      end
    end
  end

  assign o_stat_fwd_cnt  = r_fwd_cnt;
  assign o_stat_drop_cnt = r_drop_cnt;
`else
  assign o_stat_fwd_cnt  = '0;
  assign o_stat_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_reli_rx_seq_check.sv
// -----------------------------------------------------------------------------
// tb_reli_rx_seq_check
// Scoreboard bench for reli_rx_seq_check: the sender consults a reference
// PSN table, queues the beats it expects to see forwarded and the ACK words it
// expects, and negedge monitors pop and compare what the DUT produces.
// -----------------------------------------------------------------------------
module tb_reli_rx_seq_check;

  localparam int DW = 128;
  localparam int KW = 16;
  localparam int UW = 71;
  localparam int FW = 5;
  localparam int PW = 32;
  localparam int AW = 2 + FW + PW;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic [UW-1:0] user;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] ack_info;
  logic          ack_valid;
  logic          ack_rdy;
  logic          clr_v;
  logic [FW-1:0] clr_idx;
  logic [31:0]   fwd_cnt;
  logic [31:0]   drop_cnt;
  logic          m_rdy;
  logic          bp_en;
  logic          r_bp;

  always #5 clk = ~clk;

  reli_rx_seq_check_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW)) s_if ();
  reli_rx_seq_check_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW)) m_if ();

  assign m_if.tready = m_rdy & (bp_en ? r_bp : 1'b1);

  reli_rx_seq_check dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .s_axis          (s_if),
    .m_axis          (m_if),
    .o_ack_info      (ack_info),
    .o_ack_valid     (ack_valid),
    .i_ack_ready     (ack_rdy),
    .i_flow_clr_valid(clr_v),
    .i_flow_clr_idx  (clr_idx),
    .o_stat_fwd_cnt  (fwd_cnt),
    .o_stat_drop_cnt (drop_cnt)
  );

  int            n_vec = 0;
  int            n_err = 0;
  beat_t         beat_q[$];
  logic [AW-1:0] ack_q[$];
  bit            mv[32];
  logic [PW-1:0] me[32];
  int            m_fwd = 0;
  int            m_drop = 0;
  beat_t         mon_b;
  logic [AW-1:0] mon_a;

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  always @(posedge clk) r_bp <= ($urandom_range(0, 3) != 0);

  always @(negedge clk) begin
    if (!rst) begin
      if (m_if.tvalid && m_if.tready) begin
        if (beat_q.size() == 0) begin
          check_eq("beat_unexpected", 1, 0);
        end else begin
          mon_b = beat_q.pop_front();
          check_eq("beat_data", m_if.tdata, mon_b.data);
          check_eq("beat_keep", m_if.tkeep, mon_b.keep);
          check_eq("beat_last", m_if.tlast, mon_b.last);
          check_eq("beat_user", m_if.tuser, mon_b.user);
        end
      end
      if (ack_valid && ack_rdy) begin
        if (ack_q.size() == 0) begin
          check_eq("ack_unexpected", 1, 0);
        end else begin
          mon_a = ack_q.pop_front();
          check_eq("ack_word", ack_info, mon_a);
        end
      end
    end
  end

  task automatic send_pkt(input logic [FW-1:0] flow, input logic [PW-1:0] psn, input bit reli,
                          input int nb, input bit clr_last);
    bit            fwd;
    bit            ack;
    logic [1:0]    ty;
    logic [PW-1:0] apsn;
    logic [PW-1:0] d;
    beat_t         b;
    int            t;
    fwd  = 1'b1;
    ack  = 1'b0;
    ty   = 2'b00;
    apsn = '0;
    if (reli) begin
      ack = 1'b1;
      if (!mv[flow]) begin
        ty = 2'b01; apsn = psn;
      end else begin
        d = psn - me[flow];
        if (d == 0) begin
          ty = 2'b01; apsn = psn;
        end else if (!d[PW-1]) begin
          fwd = 1'b0; ty = 2'b10; apsn = me[flow];
        end else begin
          fwd = 1'b0; ty = 2'b01; apsn = me[flow] - 1;
        end
      end
    end
    if (ack) ack_q.push_back({ty, flow, apsn});
    for (int i = 0; i < nb; i++) begin
      b.data = {$urandom, $urandom, $urandom, $urandom};
      b.keep = (i == nb - 1) ? (KW'($urandom) | KW'(1)) : '1;
      b.last = (i == nb - 1);
      b.user = {$urandom, 1'($urandom), reli, flow, psn};
      s_if.tdata  = b.data;
      s_if.tkeep  = b.keep;
      s_if.tlast  = b.last;
      s_if.tuser  = b.user;
      s_if.tvalid = 1'b1;
      if (fwd) beat_q.push_back(b);
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!s_if.tready && t < 200);
      if (!s_if.tready) begin
        check_eq("s_tready_timeout", s_if.tready, 1);
        break;
      end
      if (clr_last && b.last) begin
        clr_v   = 1'b1;
        clr_idx = flow;
      end
      @(posedge clk);
      #1;
      clr_v = 1'b0;
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    if (fwd) begin
      m_fwd++;
      if (reli) begin
        me[flow] = psn + 1;
        mv[flow] = 1'b1;
      end
    end else begin
      m_drop++;
    end
    if (clr_last) mv[flow] = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((beat_q.size() != 0 || ack_q.size() != 0) && t < 500) begin
      @(posedge clk);
      t++;
    end
    #1;
    check_eq("drain_beats", beat_q.size(), 0);
    check_eq("drain_acks", ack_q.size(), 0);
  endtask

  task automatic check_stats();
`ifdef RELI_RX_STAT_EN
    check_eq("stat_fwd", fwd_cnt, m_fwd);
    check_eq("stat_drop", drop_cnt, m_drop);
`else
    check_eq("stat_fwd_tied", fwd_cnt, 0);
    check_eq("stat_drop_tied", drop_cnt, 0);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [PW-1:0] p;
    int            t;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tkeep  = '0;
    s_if.tlast  = 1'b0;
    s_if.tuser  = '0;
    m_rdy   = 1'b1;
    bp_en   = 1'b0;
    ack_rdy = 1'b1;
    clr_v   = 1'b0;
    clr_idx = '0;
    for (int i = 0; i < 32; i++) begin
      mv[i] = 1'b0;
      me[i] = '0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_m_tvalid", m_if.tvalid, 0);
    check_eq("rst_s_tready", s_if.tready, 0);
    check_eq("rst_ack_valid", ack_valid, 0);
    check_eq("rst_ack_info", ack_info, 0);
    check_stats();
    rst = 1'b0;

    // First packet on an invalid entry, then in-order, then duplicate.
    send_pkt(5'd3, 32'd100, 1'b1, 4, 1'b0);
    drain();
    check_stats();
    send_pkt(5'd3, 32'd101, 1'b1, 3, 1'b0);
    send_pkt(5'd3, 32'd101, 1'b1, 2, 1'b0);
    drain();
    check_stats();
    // Ahead: NACK, entry unchanged so 102 is still in order.
    send_pkt(5'd3, 32'd105, 1'b1, 1, 1'b0);
    send_pkt(5'd3, 32'd102, 1'b1, 1, 1'b0);
    drain();
    // PSN wrap on flow 5.
    send_pkt(5'd5, 32'hFFFF_FFFE, 1'b1, 2, 1'b0);
    send_pkt(5'd5, 32'hFFFF_FFFF, 1'b1, 1, 1'b0);
    send_pkt(5'd5, 32'h0000_0000, 1'b1, 2, 1'b0);
    drain();
    // Non-reliable: no ACK and flow 7 stays invalid.
    send_pkt(5'd7, 32'h0000_DEAD, 1'b0, 3, 1'b0);
    drain();
    check_eq("nonreli_no_ack", ack_valid, 0);
    send_pkt(5'd7, 32'd77, 1'b1, 1, 1'b0);
    drain();
    // Random downstream back-pressure with a mix of in-order and duplicates.
    bp_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      p = me[9] - PW'(($urandom_range(0, 3) == 0) ? 1 : 0);
      send_pkt(5'd9, p, 1'b1, $urandom_range(1, 4), 1'b0);
    end
    bp_en = 1'b0;
    drain();
    check_stats();
    // ACK channel back-pressure: second word waits behind the first.
    ack_rdy = 1'b0;
    send_pkt(5'd10, 32'd1000, 1'b1, 2, 1'b0);
    send_pkt(5'd10, 32'd1001, 1'b1, 2, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    check_eq("ackbp_valid", ack_valid, 1);
    check_eq("ackbp_held", ack_info, {2'b01, 5'd10, 32'd1000});
    check_eq("ackbp_queued", ack_q.size(), 2);
    ack_rdy = 1'b1;
    drain();
    // Clear coincident with tlast of an in-order packet wins.
    send_pkt(5'd3, 32'd103, 1'b1, 2, 1'b1);
    send_pkt(5'd3, 32'd500, 1'b1, 2, 1'b0);
    drain();
    check_stats();

    // Reset in the middle of a forwarded packet.
    s_if.tdata  = {$urandom, $urandom, $urandom, $urandom};
    s_if.tkeep  = '1;
    s_if.tlast  = 1'b0;
    s_if.tuser  = {33'd0, 1'b0, 5'd4, 32'd7};
    s_if.tvalid = 1'b1;
    mon_b.data = s_if.tdata;
    mon_b.keep = s_if.tkeep;
    mon_b.last = 1'b0;
    mon_b.user = s_if.tuser;
    beat_q.push_back(mon_b);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!s_if.tready && t < 50);
    check_eq("midrst_first_beat", s_if.tready, 1);
    @(posedge clk);
    #1;
    s_if.tdata = {$urandom, $urandom, $urandom, $urandom};
    m_rdy = 1'b0;
    rst   = 1'b1;
    @(posedge clk);
    #1;
    m_rdy = 1'b1;
    check_eq("midrst_m_tvalid", m_if.tvalid, 0);
    check_eq("midrst_s_tready", s_if.tready, 0);
    check_eq("midrst_ack_valid", ack_valid, 0);
    check_eq("midrst_ack_info", ack_info, 0);
    s_if.tvalid = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 32; i++) mv[i] = 1'b0;
    m_fwd  = 0;
    m_drop = 0;
    check_stats();
    check_eq("midrst_beatq", beat_q.size(), 0);
    // Table was cleared: 900 on flow 3 is taken as a first packet.
    send_pkt(5'd3, 32'd900, 1'b1, 1, 1'b0);
    drain();
    check_stats();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
